// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg : state encoding and branch constants for seq_fsm  Rev 1.0   |
// +----------------------------------------------------------------------+
package seq_pkg;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10
  } state_t;

  localparam state_t S_RECOVER = S4;
  localparam int     S_LAST    = 10;

  // Branch targets out of S8, indexed by sel
  localparam logic [1:0] SEL_S2  = 2'd0;
  localparam logic [1:0] SEL_S4  = 2'd1;
  localparam logic [1:0] SEL_S10 = 2'd2;
  localparam logic [1:0] SEL_S9  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_wrap_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_wrap_cnt : free-running wrap counter with increment    Rev 1.0   |
// +----------------------------------------------------------------------+
module seq_wrap_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_fsm : 11-state sequence generator with force/illegal   Rev 1.0   |
// +----------------------------------------------------------------------+
module seq_fsm
  import seq_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [1:0]         sel,
  input  logic               force_en,
  input  logic [STATE_W-1:0] force_val,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] old_state,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic               illegal
);

  logic [STATE_W-1:0] nxt;
  logic               wrap_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      old_state <= '0;
    end else begin
      old_state <= state;
      state     <= force_en ? force_val : nxt;
    end
  end

  // Any value above S_LAST, including nonzero bits above bit 3, recovers
  always_comb begin
    nxt = STATE_W'(S_RECOVER);
    if (state <= STATE_W'(S_LAST)) begin
      unique case (state_t'(state[3:0]))
        S0:  nxt = STATE_W'(S1);
        S1:  nxt = go ? STATE_W'(S4) : STATE_W'(S2);
        S2:  nxt = STATE_W'(S3);
        S3:  nxt = go ? STATE_W'(S1) : STATE_W'(S5);
        S4:  nxt = STATE_W'(S5);
        S5:  nxt = go ? STATE_W'(S1) : STATE_W'(S6);
        S6:  nxt = STATE_W'(S7);
        S7:  nxt = go ? STATE_W'(S8) : STATE_W'(S0);
        S8: begin
          case (sel)
            SEL_S2:  nxt = STATE_W'(S2);
            SEL_S4:  nxt = STATE_W'(S4);
            SEL_S10: nxt = STATE_W'(S10);
            SEL_S9:  nxt = STATE_W'(S9);
            default: nxt = STATE_W'(S_RECOVER);
          endcase
        end
        S9:  nxt = go ? STATE_W'(S0) : STATE_W'(S8);
        S10: nxt = STATE_W'(S0);
        default: nxt = STATE_W'(S_RECOVER);
      endcase
    end
  end

  // Only 7, 9 and 10 lead to S0 through nxt, so this excludes reset and force
  assign wrap_inc = !force_en && (nxt == '0);

  seq_wrap_cnt #(
    .CNT_W (CNT_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_inc),
    .count (wrap_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (state > STATE_W'(S_LAST)) begin
      illegal <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_fsm : directed vector bench for seq_fsm             Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_seq_fsm;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               rst;
  logic               go;
  logic [1:0]         sel;
  logic               force_en;
  logic [STATE_W-1:0] force_val;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] old_state;
  logic [CNT_W-1:0]   wrap_cnt;
  logic               illegal;

  int total;
  int bad;

  typedef struct {
    logic       go;
    logic [1:0] sel;
    logic       fe;
    logic [3:0] fv;
    logic [3:0] st;
    logic [3:0] old;
    logic [7:0] wc;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  seq_fsm #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .sel       (sel),
    .force_en  (force_en),
    .force_val (force_val),
    .state     (state),
    .old_state (old_state),
    .wrap_cnt  (wrap_cnt),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic g, input logic [1:0] s, input logic fe, input logic [3:0] fv,
                     input logic [3:0] st, input logic [3:0] old, input logic [7:0] wc,
                     input logic ill);
    vec_t v;
    v.go = g; v.sel = s; v.fe = fe; v.fv = fv;
    v.st = st; v.old = old; v.wc = wc; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [3:0] old,
                           input logic [7:0] wc, input logic ill);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".old_state"}, 32'(old_state), 32'(old));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(wc));
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    logic [7:0] exp_wc;
    total = 0;
    bad   = 0;

    // go, sel, force_en, force_val, state, old_state, wrap_cnt, illegal
    add(0, 0, 0, 0,  1,  0, 0, 0);
    add(0, 0, 0, 0,  2,  1, 0, 0);
    add(1, 0, 0, 0,  3,  2, 0, 0);
    add(0, 0, 0, 0,  5,  3, 0, 0);
    add(0, 0, 0, 0,  6,  5, 0, 0);
    add(1, 0, 0, 0,  7,  6, 0, 0);
    add(0, 0, 0, 0,  0,  7, 1, 0);
    add(1, 0, 0, 0,  1,  0, 1, 0);
    add(1, 0, 0, 0,  4,  1, 1, 0);
    add(1, 0, 0, 0,  5,  4, 1, 0);
    add(1, 0, 0, 0,  1,  5, 1, 0);
    add(1, 0, 0, 0,  4,  1, 1, 0);
    add(1, 0, 0, 0,  5,  4, 1, 0);
    add(0, 0, 0, 0,  6,  5, 1, 0);
    add(0, 0, 0, 0,  7,  6, 1, 0);
    add(1, 0, 0, 0,  8,  7, 1, 0);
    add(0, 2, 0, 0, 10,  8, 1, 0);
    add(1, 0, 0, 0,  0, 10, 2, 0);
    add(0, 0, 0, 0,  1,  0, 2, 0);
    add(0, 0, 0, 0,  2,  1, 2, 0);
    add(1, 0, 0, 0,  3,  2, 2, 0);
    add(0, 0, 0, 0,  5,  3, 2, 0);
    add(0, 0, 0, 0,  6,  5, 2, 0);
    add(0, 0, 0, 0,  7,  6, 2, 0);
    add(1, 0, 0, 0,  8,  7, 2, 0);
    add(0, 3, 0, 0,  9,  8, 2, 0);
    add(0, 0, 0, 0,  8,  9, 2, 0);
    add(0, 1, 0, 0,  4,  8, 2, 0);
    add(0, 0, 0, 0,  5,  4, 2, 0);
    add(0, 0, 0, 0,  6,  5, 2, 0);
    add(0, 0, 0, 0,  7,  6, 2, 0);
    add(1, 0, 0, 0,  8,  7, 2, 0);
    add(1, 0, 0, 0,  2,  8, 2, 0);
    add(0, 0, 0, 0,  3,  2, 2, 0);
    add(1, 0, 0, 0,  1,  3, 2, 0);
    add(1, 0, 0, 0,  4,  1, 2, 0);
    add(0, 0, 0, 0,  5,  4, 2, 0);
    add(0, 0, 0, 0,  6,  5, 2, 0);
    add(0, 0, 0, 0,  7,  6, 2, 0);
    add(1, 0, 0, 0,  8,  7, 2, 0);
    add(0, 3, 0, 0,  9,  8, 2, 0);
    add(1, 0, 0, 0,  0,  9, 3, 0);
    add(0, 0, 0, 0,  1,  0, 3, 0);
    // illegal-state injection and recovery
    add(0, 0, 1, 12, 12, 1, 3, 0);
    add(0, 0, 0, 0,  4, 12, 3, 1);
    add(0, 0, 0, 0,  5,  4, 3, 1);
    // forcing 0 must not count as a wrap
    add(0, 0, 1, 0,  0,  5, 3, 1);
    add(0, 0, 0, 0,  1,  0, 3, 1);
    add(1, 0, 1, 11, 11, 1, 3, 1);
    add(0, 0, 0, 0,  4, 11, 3, 1);
    add(0, 0, 0, 0,  5,  4, 3, 1);
    add(0, 0, 0, 0,  6,  5, 3, 1);

    rst = 1'b1; go = 1'b0; sel = 2'd0; force_en = 1'b0; force_val = '0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      go        = vecs[i].go;
      sel       = vecs[i].sel;
      force_en  = vecs[i].fe;
      force_val = vecs[i].fv;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].old, vecs[i].wc, vecs[i].ill);
    end

    // Reset at state 6 beats a simultaneous force
    go = 1'b0; force_en = 1'b1; force_val = 4'd13; rst = 1'b1;
    tick();
    check_all("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; force_en = 1'b0; force_val = '0;
    tick();
    check_all("post_rst", 1, 0, 0, 0);
    tick(); tick(); tick(); tick(); tick(); tick();
    check_all("lap0_end", 0, 7, 1, 0);

    // Long run of 0..7->0 laps to cross the counter wrap
    exp_wc = 8'd1;
    for (int lap = 0; lap < 256; lap++) begin
      for (int c = 0; c < 7; c++) tick();
      exp_wc = exp_wc + 8'd1;
      check($sformatf("lap%0d.wrap_cnt", lap), 32'(wrap_cnt), 32'(exp_wc));
      check($sformatf("lap%0d.state", lap), 32'(state), 32'd0);
      if (exp_wc == 8'd255) begin
        for (int c = 0; c < 7; c++) tick();
        exp_wc = exp_wc + 8'd1;
        check("wrap_255_to_0", 32'(wrap_cnt), 32'd0);
        break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
